unidade_adiantamento: RTL and testbench
=======================================

UNIDADE_ADIANTAMENTO -- requirements
Module: unidade_adiantamento

Interface
REQ-001 Parameter REG_BITS, default 5, SHALL set the width of register-index fields.
REQ-002 Parameter CONT_BITS, default 16, SHALL set the width of the bubble counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous and active-low.
REQ-005 id_valido  input  1  SHALL flag a valid instruction in the ID stage.
REQ-006 id_rs1, id_rs2  input  REG_BITS  SHALL carry the source register indices of the ID instruction.
REQ-007 id_rd  input  REG_BITS  SHALL carry the destination index of the ID instruction.
REQ-008 id_regwrite, id_memread  input  1  SHALL flag that the ID instruction writes a register or is a load.
REQ-009 flush  input  1  SHALL request that the ID instruction be discarded (taken branch resolved in EX).
REQ-010 seletor_a, seletor_b  output  2  SHALL drive the EX-stage operand-mux selects: 00 register file, 10 EX/MEM result, 01 MEM/WB result; 11 is never driven.
REQ-011 stall  output  1  SHALL request that PC and IF/ID hold for one cycle.
REQ-012 cont_bolhas  output  CONT_BITS  SHALL count inserted bubbles.

Function
REQ-013 The block SHALL keep shadow state for slot EX (valid, rd, regwrite, memread) and slot MEM (valid, rd, regwrite).
REQ-014 stall SHALL be combinational: id_valido & ex_valid & ex_memread & ex_regwrite & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) & !flush.
REQ-015 Both source fields SHALL always be compared, even for instructions that do not use rs2 (conservative stall).
REQ-016 Each edge, MEM slot SHALL load the current EX slot unconditionally.
REQ-017 Each edge, EX slot SHALL load the ID fields when id_valido & !stall & !flush; otherwise it SHALL load a bubble (valid=0, regwrite=0, memread=0, rd=0).
REQ-018 seletor_a SHALL be registered with 1-cycle latency, updated on the same edge as EX slot: 10 if EX slot valid, regwrite, rd!=0 and rd==id_rs1; else 01 if MEM slot valid, regwrite, rd!=0 and rd==id_rs1; else 00.
REQ-019 seletor_b SHALL follow REQ-018 using id_rs2.
REQ-020 The EX match SHALL take priority over the MEM match when both hit (newest value wins).
REQ-021 When EX slot loads a bubble (REQ-017), both selectors SHALL load 00.
REQ-022 Register index 0 SHALL never produce forwarding or stall.
REQ-023 flush SHALL take priority over stall; with both conditions, stall=0 and a bubble is inserted.
REQ-024 The register file SHALL write-through in WB, so no forwarding from beyond MEM/WB is produced.
REQ-025 cont_bolhas SHALL increment by 1 on each edge where stall=1 or flush=1, saturating at all ones (no wrap).

Reset
REQ-026 rst_n low SHALL immediately clear EX and MEM slots to bubbles, seletor_a/b to 00, cont_bolhas to 0; stall then evaluates to 0.
REQ-027 Reset asserted mid-stall SHALL drop stall combinationally in the same cycle; the first edge after release SHALL accept the ID instruction normally.

Verification
REQ-028 add x5 in ID, then sub rs1=x5 next cycle -> after second edge seletor_a=10, seletor_b=00, stall never 1.
REQ-029 add x7 followed by nop then or rs2=x7 -> or enters EX with seletor_b=01, seletor_a=00.
REQ-030 lw x3 then add rs1=x3 -> stall=1 for exactly one cycle, bubble in EX, then add enters EX with seletor_a=01; cont_bolhas=1.
REQ-031 Two back-to-back writers of x4 then reader of x4 -> seletor_a=10 (EX priority); writer to x0 then reader of x0 -> selectors 00.
REQ-032 lw x3 + dependent add with flush=1 in the same cycle -> stall=0, selectors 00, cont_bolhas increments by 1.
REQ-033 With CONT_BITS=2, four consecutive stalls -> cont_bolhas reads 3 and holds; rst_n pulse low -> all outputs 00/0 without waiting for clk.

Source files
------------

// File: rtl/unidade_adiantamento_if.sv
// unidade_adiantamento_if
// Bundles the ID-stage request fields and the forwarding/hazard responses
// exchanged between the pipeline control and unidade_adiantamento.
//   master : drives the ID instruction fields and flush, reads the responses
//   slave  : the forwarding unit itself
interface unidade_adiantamento_if #(
    parameter int REG_BITS  = 5,
    parameter int CONT_BITS = 16
);
    logic                 id_valido;
    logic [REG_BITS-1:0]  id_rs1;
    logic [REG_BITS-1:0]  id_rs2;
    logic [REG_BITS-1:0]  id_rd;
    logic                 id_regwrite;
    logic                 id_memread;
    logic                 flush;
    logic [1:0]           seletor_a;
    logic [1:0]           seletor_b;
    logic                 stall;
    logic [CONT_BITS-1:0] cont_bolhas;

    modport master (
        output id_valido, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, flush,
        input  seletor_a, seletor_b, stall, cont_bolhas
    );

    modport slave (
        input  id_valido, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, flush,
        output seletor_a, seletor_b, stall, cont_bolhas
    );
endinterface

// File: rtl/unidade_adiantamento.sv
// unidade_adiantamento
// Forwarding and load-use hazard unit for a 5-stage pipeline. Shadows the
// EX and MEM slots and, on each edge, registers the operand-mux selects for
// the instruction entering EX. Raises a combinational stall on a load-use
// hazard and counts every inserted bubble (stall or flush).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of unidade_adiantamento_if (ID fields, flush in;
//           seletor_a/b, stall, cont_bolhas out)
// Selector encoding: 00 register file, 10 EX/MEM result, 01 MEM/WB result.
module unidade_adiantamento #(
    parameter int REG_BITS  = 5,
    parameter int CONT_BITS = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    unidade_adiantamento_if.slave   bus
);
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b10;
    localparam logic [1:0] SEL_MEM = 2'b01;

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] rd;
        logic                regwrite;
        logic                memread;
    } slot_t;

    localparam slot_t BUBBLE = '{valid: 1'b0, rd: '0, regwrite: 1'b0, memread: 1'b0};

    slot_t                ex_q, ex_d;
    slot_t                mem_q, mem_d;
    logic [1:0]           sel_a_q, sel_a_d;
    logic [1:0]           sel_b_q, sel_b_d;
    logic [CONT_BITS-1:0] cont_q, cont_d;
    logic                 stall;
    logic                 accept;

    // A slot can supply a value only if it really writes a nonzero register.
    function automatic logic hit(input slot_t s, input logic [REG_BITS-1:0] rs);
        return s.valid && s.regwrite && (s.rd != '0) && (s.rd == rs);
    endfunction

    // EX checked first: the newest producer wins.
    function automatic logic [1:0] pick(input slot_t ex, input slot_t mem,
                                        input logic [REG_BITS-1:0] rs);
        if (hit(ex, rs))       return SEL_EX;
        else if (hit(mem, rs)) return SEL_MEM;
        else                   return SEL_RF;
    endfunction

    // Both sources are compared even when the instruction ignores rs2;
    // a spurious stall costs one cycle but is never wrong. flush wins.
    always_comb begin
        stall = bus.id_valido && ex_q.valid && ex_q.memread && ex_q.regwrite &&
                (ex_q.rd != '0) &&
                ((ex_q.rd == bus.id_rs1) || (ex_q.rd == bus.id_rs2)) &&
                !bus.flush;
    end

    assign accept = bus.id_valido && !stall && !bus.flush;

    always_comb begin
        mem_d   = ex_q;
        ex_d    = BUBBLE;
        sel_a_d = SEL_RF;
        sel_b_d = SEL_RF;
        if (accept) begin
            ex_d.valid    = 1'b1;
            ex_d.rd       = bus.id_rd;
            ex_d.regwrite = bus.id_regwrite;
            ex_d.memread  = bus.id_memread;
            // Current EX/MEM slots become MEM/WB next cycle, matching the
            // mux inputs the entering instruction will see.
            sel_a_d       = pick(ex_q, mem_q, bus.id_rs1);
            sel_b_d       = pick(ex_q, mem_q, bus.id_rs2);
        end
        cont_d = cont_q;
        if ((stall || bus.flush) && (cont_q != '1))
            cont_d = cont_q + CONT_BITS'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= BUBBLE;
            mem_q   <= BUBBLE;
            sel_a_q <= SEL_RF;
            sel_b_q <= SEL_RF;
            cont_q  <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            cont_q  <= cont_d;
        end
    end

    assign bus.seletor_a   = sel_a_q;
    assign bus.seletor_b   = sel_b_q;
    assign bus.stall       = stall;
    assign bus.cont_bolhas = cont_q;
endmodule

// File: tb/tb_unidade_adiantamento.sv
// Directed bench for unidade_adiantamento. Two instances share the same
// stimulus: one with the default 16-bit bubble counter, one with a 2-bit
// counter to exercise saturation. Expected values are pushed into a
// scoreboard queue by the stimulus; a monitor pops and compares them.
module tb_unidade_adiantamento;
    logic clk;
    logic rst_n;

    logic       id_valido, id_regwrite, id_memread, flush;
    logic [4:0] id_rs1, id_rs2, id_rd;

    unidade_adiantamento_if #(.REG_BITS(5), .CONT_BITS(16)) bus_a ();
    unidade_adiantamento_if #(.REG_BITS(5), .CONT_BITS(2))  bus_b ();

    assign bus_a.id_valido   = id_valido;
    assign bus_a.id_rs1      = id_rs1;
    assign bus_a.id_rs2      = id_rs2;
    assign bus_a.id_rd       = id_rd;
    assign bus_a.id_regwrite = id_regwrite;
    assign bus_a.id_memread  = id_memread;
    assign bus_a.flush       = flush;
    assign bus_b.id_valido   = id_valido;
    assign bus_b.id_rs1      = id_rs1;
    assign bus_b.id_rs2      = id_rs2;
    assign bus_b.id_rd       = id_rd;
    assign bus_b.id_regwrite = id_regwrite;
    assign bus_b.id_memread  = id_memread;
    assign bus_b.flush       = flush;

    unidade_adiantamento #(.REG_BITS(5), .CONT_BITS(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
    );
    unidade_adiantamento #(.REG_BITS(5), .CONT_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic        st;
        logic [15:0] c;
        logic [1:0]  c2;
        string       nm;
    } exp_t;

    exp_t sbq[$];
    int   n_pass  = 0;
    int   n_total = 0;
    event chk_ev;

    // Monitor: every negedge (or on demand for async events) drain the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                n_total++;
                if (bus_a.seletor_a === e.sa && bus_a.seletor_b === e.sb &&
                    bus_a.stall === e.st && bus_a.cont_bolhas === e.c &&
                    bus_b.seletor_a === e.sa && bus_b.seletor_b === e.sb &&
                    bus_b.stall === e.st && bus_b.cont_bolhas === e.c2)
                    n_pass++;
                else
                    $display("FAIL %s: got a=%b b=%b st=%b cnt=%0d cnt2=%0d (b: a=%b b=%b st=%b) exp a=%b b=%b st=%b cnt=%0d cnt2=%0d",
                             e.nm, bus_a.seletor_a, bus_a.seletor_b, bus_a.stall,
                             bus_a.cont_bolhas, bus_b.cont_bolhas,
                             bus_b.seletor_a, bus_b.seletor_b, bus_b.stall,
                             e.sa, e.sb, e.st, e.c, e.c2);
            end
        end
    end

    task automatic push_exp(input logic [1:0] sa, input logic [1:0] sb,
                            input logic st, input int c, input int c2,
                            input string nm);
        exp_t e;
        e.sa = sa; e.sb = sb; e.st = st;
        e.c  = 16'(c); e.c2 = 2'(c2); e.nm = nm;
        sbq.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic mr,
                         input logic fl);
        id_valido = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_regwrite = rw; id_memread = mr; flush = fl;
    endtask

    // One cycle: apply ID inputs, queue the expected outputs for this cycle.
    task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic rw, input logic mr,
                        input logic fl, input logic [1:0] sa, input logic [1:0] sb,
                        input logic st, input int c, input int c2, input string nm);
        drive(v, rs1, rs2, rd, rw, mr, fl);
        push_exp(sa, sb, st, c, c2, nm);
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic [1:0] sa, input logic [1:0] sb,
                       input int c, input int c2, input string nm);
        step(0, 0, 0, 0, 0, 0, 0, sa, sb, 0, c, c2, nm);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        nop(2'b00, 2'b00, 0, 0, "reset_state");
        rst_n = 1'b1;

        // EX forwarding: add x5 then sub rs1=x5
        step(1, 1, 2, 5, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, "add_x5");
        step(1, 5, 6, 8, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, "sub_in_id");
        nop(2'b10, 2'b00, 0, 0, "ex_fwd_a");
        // MEM forwarding: add x7, nop, or rs2=x7
        step(1, 0, 0, 7, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, "add_x7");
        nop(2'b00, 2'b00, 0, 0, "gap_nop");
        step(1, 1, 7, 9, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, "or_in_id");
        nop(2'b00, 2'b01, 0, 0, "mem_fwd_b");
        // Load-use: lw x3 then add rs1=x3
        step(1, 0, 0, 3, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0, "lw_x3");
        step(1, 3, 4, 10, 1, 0, 0, 2'b00, 2'b00, 1, 0, 0, "load_use_stall");
        step(1, 3, 4, 10, 1, 0, 0, 2'b00, 2'b00, 0, 1, 1, "stall_one_cycle");
        nop(2'b01, 2'b00, 1, 1, "load_fwd_mem");
        // Two writers of x4 then reader: EX wins
        step(1, 0, 0, 4, 1, 0, 0, 2'b00, 2'b00, 0, 1, 1, "wr_x4_a");
        step(1, 0, 0, 4, 1, 0, 0, 2'b00, 2'b00, 0, 1, 1, "wr_x4_b");
        step(1, 4, 0, 11, 1, 0, 0, 2'b00, 2'b00, 0, 1, 1, "rd_x4");
        // Writer to x0 then reader of x0
        step(1, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 0, 1, 1, "ex_priority");
        step(1, 0, 0, 12, 1, 0, 0, 2'b00, 2'b00, 0, 1, 1, "rd_x0");
        nop(2'b00, 2'b00, 1, 1, "x0_no_fwd");
        // Load into x0 never stalls
        step(1, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 1, 1, "lw_x0");
        step(1, 0, 0, 13, 1, 0, 0, 2'b00, 2'b00, 0, 1, 1, "x0_no_stall");
        // flush beats stall
        step(1, 0, 0, 3, 1, 1, 0, 2'b00, 2'b00, 0, 1, 1, "lw_x3_b");
        step(1, 3, 0, 14, 1, 0, 1, 2'b00, 2'b00, 0, 1, 1, "flush_over_stall");
        nop(2'b00, 2'b00, 2, 2, "flush_bubble");
        // More bubbles; 2-bit counter saturates at 3
        step(1, 0, 0, 3, 1, 1, 0, 2'b00, 2'b00, 0, 2, 2, "lw_x3_c");
        step(1, 3, 0, 15, 1, 0, 0, 2'b00, 2'b00, 1, 2, 2, "stall_rs1");
        step(1, 0, 0, 3, 1, 1, 0, 2'b00, 2'b00, 0, 3, 3, "lw_x3_d");
        step(1, 0, 3, 16, 1, 0, 0, 2'b00, 2'b00, 1, 3, 3, "stall_rs2");
        step(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 4, 3, "sat_flush");
        nop(2'b00, 2'b00, 5, 3, "saturated");
        // Async reset in the middle of a stall cycle
        step(1, 0, 0, 3, 1, 1, 0, 2'b00, 2'b00, 0, 5, 3, "lw_x3_e");
        drive(1, 3, 0, 17, 1, 0, 0);
        push_exp(2'b00, 2'b00, 1, 5, 3, "stall_pre_reset");
        #6;
        rst_n = 1'b0;
        #1;
        push_exp(2'b00, 2'b00, 0, 0, 0, "async_reset");
        ->chk_ev;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1, 17, 0, 18, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, "accept_after_reset");
        nop(2'b10, 2'b00, 0, 0, "fwd_after_reset");

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d entries left, exp 0", sbq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
